// File: rtl/imm_extend_pipe.sv
// Immediate extender: decodes the instruction immediate field into a DATA_W-wide value, carry and error flag.
// Latency: two register stages (S1 capture, S2 result); one item per cycle when out_ready stays high.
// Backpressure: a stalled S2 holds its outputs and S1 holds its item; in_ready drops only when both are full.
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_instr,
  input  logic [2:0]        in_immsrc,
  input  logic              in_cflag,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_extimm,
  output logic              out_carry,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef struct packed {
    logic [23:0]      instr;
    logic [2:0]       immsrc;
    logic             cflag;
    logic [TAG_W-1:0] tag;
  } s1_t;

  s1_t  s1_dat;
  logic s1_vld;
  logic s2_free;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_vld && s2_free;
  assign in_ready = !flush && (!s1_vld || s2_free);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  logic [31:0]       rot_src;
  logic [4:0]        rot_amt;
  logic [31:0]       rot_val;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_carry;
  logic              dec_err;

  always_comb begin
    rot_src   = {24'h0, s1_dat.instr[7:0]};
    rot_amt   = {s1_dat.instr[11:8], 1'b0};
    // Rotate right by shifting a doubled copy; the low word is the rotated value.
    rot_val   = 32'({rot_src, rot_src} >> rot_amt);
    dec_imm   = '0;
    dec_carry = s1_dat.cflag;
    dec_err   = 1'b0;
    case (s1_dat.immsrc)
      3'b000: dec_imm = DATA_W'(s1_dat.instr[7:0]);
      3'b001: dec_imm = DATA_W'(s1_dat.instr[11:0]);
      3'b010: dec_imm = {{(DATA_W-26){s1_dat.instr[23]}}, s1_dat.instr, 2'b00};
      3'b011: begin
        dec_imm = DATA_W'(rot_val);
        if (rot_amt != 5'd0) dec_carry = rot_val[31];
      end
      3'b100: dec_imm = {{(DATA_W-12){s1_dat.instr[11]}}, s1_dat.instr[11:0]};
      default: begin
        dec_carry = 1'b0;
        dec_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld     <= 1'b0;
      s1_dat     <= '0;
      out_valid  <= 1'b0;
      out_extimm <= '0;
      out_carry  <= 1'b0;
      out_err    <= 1'b0;
      out_tag    <= '0;
      err_cnt    <= '0;
    end else if (flush) begin
      // Flush wins over both transfers, including the error count of a departing item.
      s1_vld    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire) s1_dat <= '{instr: in_instr, immsrc: in_immsrc, cflag: in_cflag, tag: in_tag};
      s1_vld <= in_fire || (s1_vld && !s1_adv);
      if (s2_free) begin
        out_valid <= s1_vld;
        if (s1_vld) begin
          out_extimm <= dec_imm;
          out_carry  <= dec_carry;
          out_err    <= dec_err;
          out_tag    <= s1_dat.tag;
        end
      end
      if (out_fire && out_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: table-driven vectors through a scoreboard queue, plus stall, flush and reset sequences.
// A 32-bit/16-bit-counter instance and a 40-bit/2-bit-counter instance share every input.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] in_instr = '0;
  logic [2:0]  in_immsrc = '0;
  logic        in_cflag = 1'b0;
  logic [3:0]  in_tag = '0;

  logic        in_ready, out_valid, out_carry, out_err;
  logic [31:0] out_extimm;
  logic [3:0]  out_tag;
  logic [15:0] err_cnt;

  logic        in_ready_b, out_valid_b, out_carry_b, out_err_b;
  logic [39:0] out_extimm_b;
  logic [3:0]  out_tag_b;
  logic [1:0]  err_cnt_b;

  imm_extend_pipe dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_immsrc(in_immsrc),
    .in_cflag(in_cflag), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_extimm(out_extimm), .out_carry(out_carry),
    .out_err(out_err), .out_tag(out_tag), .err_cnt(err_cnt)
  );

  imm_extend_pipe #(.DATA_W(40), .TAG_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_immsrc(in_immsrc),
    .in_cflag(in_cflag), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_extimm(out_extimm_b), .out_carry(out_carry_b),
    .out_err(out_err_b), .out_tag(out_tag_b), .err_cnt(err_cnt_b)
  );

  typedef struct {
    logic [23:0] instr;
    logic [2:0]  src;
    logic        cf;
    logic [31:0] e32;
    logic [39:0] e40;
    logic        c;
    logic        e;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [39:0] imm40;
    logic        c;
    logic        e;
    logic [3:0]  tag;
  } exp_t;

  vec_t vecs[16];
  exp_t q[$];
  exp_t cur_exp;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   m_cnt2 = 0;
  logic prev_stall = 1'b0;
  logic [31:0] p_imm = '0;
  logic [3:0]  p_tag = '0;
  logic rdy_pat = 1'b0;
  int   pcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Must be called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send(input vec_t v, input logic [3:0] tag);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_immsrc = v.src;
    in_cflag = v.cf;
    in_tag = tag;
    cur_exp.imm = v.e32;
    cur_exp.imm40 = v.e40;
    cur_exp.c = v.c;
    cur_exp.e = v.e;
    cur_exp.tag = tag;
    for (int t = 0; t < 100 && !ok; t++) begin
      #4;
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: item tag %0h never accepted", tag);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d items pending, expected 0 after %0d cycles", q.size(), t);
    end
  endtask

  task automatic mon_sample();
    exp_t e;
    chk("in_ready", 64'(in_ready), 64'((q.size() == 2) ? (!flush && out_ready) : !flush));
    chk("in_ready_b", 64'(in_ready_b), 64'(in_ready));
    chk("out_valid_b", 64'(out_valid_b), 64'(out_valid));
    chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
    chk("err_cnt_w2", 64'(err_cnt_b), 64'(m_cnt2));
    if (q.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'(0));
    if (prev_stall) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_imm", 64'(out_extimm), 64'(p_imm));
      chk("stall_tag", 64'(out_tag), 64'(p_tag));
    end
    if (flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'(0));
        end else begin
          e = q.pop_front();
          chk("extimm", 64'(out_extimm), 64'(e.imm));
          chk("extimm_w40", 64'(out_extimm_b), 64'(e.imm40));
          chk("carry", 64'(out_carry), 64'(e.c));
          chk("carry_w40", 64'(out_carry_b), 64'(e.c));
          chk("err", 64'(out_err), 64'(e.e));
          chk("tag", 64'(out_tag), 64'(e.tag));
          if (e.e) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
    prev_stall = out_valid && !out_ready && !flush;
    p_imm = out_extimm;
    p_tag = out_tag;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset_n) mon_sample();
    end
  end

  initial begin
    forever begin
      @(negedge reset_n);
      q.delete();
      m_cnt = 0;
      m_cnt2 = 0;
      prev_stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_pat) begin
        out_ready = (pcnt % 3 == 0);
        pcnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{24'hABCDEF, 3'b000, 1'b1, 32'h000000EF, 40'h00000000EF, 1'b1, 1'b0};
    vecs[1]  = '{24'h123FED, 3'b001, 1'b0, 32'h00000FED, 40'h0000000FED, 1'b0, 1'b0};
    vecs[2]  = '{24'hFFFFFE, 3'b010, 1'b0, 32'hFFFFFFF8, 40'hFFFFFFFFF8, 1'b0, 1'b0};
    vecs[3]  = '{24'h1FFFFF, 3'b010, 1'b1, 32'h007FFFFC, 40'h00007FFFFC, 1'b1, 1'b0};
    vecs[4]  = '{24'h0004FF, 3'b011, 1'b0, 32'hFF000000, 40'h00FF000000, 1'b1, 1'b0};
    vecs[5]  = '{24'h000012, 3'b011, 1'b1, 32'h00000012, 40'h0000000012, 1'b1, 1'b0};
    vecs[6]  = '{24'h000012, 3'b011, 1'b0, 32'h00000012, 40'h0000000012, 1'b0, 1'b0};
    vecs[7]  = '{24'h000F81, 3'b011, 1'b1, 32'h00000204, 40'h0000000204, 1'b0, 1'b0};
    vecs[8]  = '{24'hAB0102, 3'b011, 1'b0, 32'h80000000, 40'h0080000000, 1'b1, 1'b0};
    vecs[9]  = '{24'h5A5800, 3'b100, 1'b0, 32'hFFFFF800, 40'hFFFFFFF800, 1'b0, 1'b0};
    vecs[10] = '{24'h0007FF, 3'b100, 1'b1, 32'h000007FF, 40'h00000007FF, 1'b1, 1'b0};
    vecs[11] = '{24'hFFFFFF, 3'b101, 1'b1, 32'h00000000, 40'h0000000000, 1'b0, 1'b1};
    vecs[12] = '{24'h00005A, 3'b000, 1'b0, 32'h0000005A, 40'h000000005A, 1'b0, 1'b0};
    vecs[13] = '{24'h123456, 3'b110, 1'b1, 32'h00000000, 40'h0000000000, 1'b0, 1'b1};
    vecs[14] = '{24'h000000, 3'b111, 1'b1, 32'h00000000, 40'h0000000000, 1'b0, 1'b1};
    vecs[15] = '{24'hFFFFFF, 3'b001, 1'b1, 32'h00000FFF, 40'h0000000FFF, 1'b1, 1'b0};

    // Reset values while reset_n is low.
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_extimm", 64'(out_extimm), 64'(0));
    chk("rst_carry", 64'(out_carry), 64'(0));
    chk("rst_err", 64'(out_err), 64'(0));
    chk("rst_tag", 64'(out_tag), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Single item: S1 only after the accepting edge, result after the following edge.
    send(vecs[4], 4'hA);
    #1;
    chk("lat_s1_only", 64'(out_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("lat_s2_valid", 64'(out_valid), 64'(1));
    chk("lat_extimm", 64'(out_extimm), 64'(32'hFF000000));
    chk("lat_carry", 64'(out_carry), 64'(1));
    @(negedge clk);
    drain();

    // Vector table, back to back.
    for (int i = 0; i < 16; i++) send(vecs[i], 4'(i));
    drain();

    // Eight tagged items with out_ready cycling 1,0,0.
    rdy_pat = 1'b1;
    pcnt = 0;
    for (int i = 0; i < 8; i++) begin
      v.instr = 24'(i * 17);
      v.src = 3'b000;
      v.cf = 1'(i & 1);
      v.e32 = 32'(i * 17);
      v.e40 = 40'(i * 17);
      v.c = 1'(i & 1);
      v.e = 1'b0;
      send(v, 4'(i));
    end
    drain();
    rdy_pat = 1'b0;
    out_ready = 1'b1;

    // Three more errored items: wide counter keeps counting, 2-bit counter stays saturated.
    for (int i = 0; i < 3; i++) send(vecs[11], 4'(8 + i));
    drain();
    #1;
    chk("err_cnt_total", 64'(err_cnt), 64'(6));
    chk("err_cnt_sat", 64'(err_cnt_b), 64'(3));
    @(negedge clk);

    // Flush with a full pipeline, an input offered and the output being taken.
    out_ready = 1'b0;
    send(vecs[11], 4'h1);
    send(vecs[14], 4'h2);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 24'h00005A;
    in_immsrc = 3'b000;
    in_tag = 4'h3;
    cur_exp = '{32'h5A, 40'h5A, 1'b0, 1'b0, 4'h3};
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_err_cnt", 64'(err_cnt), 64'(6));
    chk("flush_err_cnt_w2", 64'(err_cnt_b), 64'(3));
    repeat (5) @(negedge clk);

    // Reset pulse between edges with two items in flight.
    out_ready = 1'b0;
    send(vecs[0], 4'h3);
    send(vecs[1], 4'h4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_extimm", 64'(out_extimm), 64'(0));
    chk("arst_tag", 64'(out_tag), 64'(0));
    chk("arst_err_cnt", 64'(err_cnt), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_after_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    repeat (4) @(negedge clk);
    send(vecs[12], 4'h5);
    drain();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
